// File: rtl/fir_tap_scheduler.sv
// fir_tap_scheduler
//
// Time-multiplexed controller for an N-tap FIR filter. One signed 8x8
// multiply-accumulate unit is stepped over all N taps for each accepted
// sample. The block owns the circular sample history, the coefficient
// register file, the tap sequencing FSM and both valid/ready handshakes.
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   x_n        signed 8-bit input sample
//   x_valid    x_n valid
//   x_ready    block accepts a sample this cycle (high only in IDLE)
//   y_n        signed 16-bit filter output, updated only on entry to HOLD
//   y_valid    y_n valid; held until y_ready
//   y_ready    consumer accepts y_n
//   coef_we    coefficient write strobe (honoured only in IDLE)
//   coef_addr  coefficient index k
//   coef_data  signed 8-bit coefficient h[k]
//   busy       high while in MAC or HOLD
//
// Build option:
//   FIR_SAT_EN  when defined, the accumulator is clamped to [-32768, 32767]
//               when loaded into y_n; otherwise y_n takes acc[15:0] (wrap).
//
// Timing: sample accepted at edge T, MAC steps on edges T+1..T+N, the result
// is loaded into y_n on edge T+N+1, and the handshake completes at T+N+2 with
// y_ready held high, giving one sample per N+3 cycles.

module fir_tap_scheduler #(
    parameter int unsigned N  = 32,
    parameter int unsigned AW = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [7:0]    x_n,
    input  logic                 x_valid,
    output logic                 x_ready,
    output logic signed [15:0]   y_n,
    output logic                 y_valid,
    input  logic                 y_ready,
    input  logic                 coef_we,
    input  logic [AW-1:0]        coef_addr,
    input  logic signed [7:0]    coef_data,
    output logic                 busy
);

    // Wide enough for N products of 16 bits without overflow.
    localparam int unsigned AccW = 16 + AW;

    typedef enum logic [1:0] {
        StIdle,
        StMac,
        StHold
    } state_e;

    state_e                    state_q;
    logic signed [7:0]         hist_q [N];
    logic signed [7:0]         h_q    [N];
    logic [AW-1:0]             wr_ptr_q;
    logic [AW-1:0]             cur_ptr_q;
    // One bit wider than a tap index: k_q[AW] set means all N taps are done
    // and this cycle loads the result.
    logic [AW:0]               k_q;
    logic signed [AccW-1:0]    acc_q;
    logic signed [15:0]        y_n_q;
    logic                      y_valid_q;

    logic [AW-1:0]             tap_idx;
    logic signed [15:0]        prod;
    logic signed [AccW-1:0]    prod_ext;
    logic signed [15:0]        y_load;

    // History index wraps modulo N through the natural AW-bit subtraction.
    always_comb begin
        tap_idx  = cur_ptr_q - k_q[AW-1:0];
        prod     = h_q[k_q[AW-1:0]] * hist_q[tap_idx];
        prod_ext = AccW'(prod);
    end

`ifdef FIR_SAT_EN
    localparam logic signed [AccW-1:0] SatMax = AccW'(32767);
    localparam logic signed [AccW-1:0] SatMin = AccW'(-32768);

    always_comb begin
        y_load = acc_q[15:0];
        if (acc_q > SatMax) begin
            y_load = 16'sh7fff;
        end else if (acc_q < SatMin) begin
            y_load = 16'sh8000;
        end
    end
`else
    always_comb begin
        y_load = acc_q[15:0];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            wr_ptr_q  <= '0;
            cur_ptr_q <= '0;
            k_q       <= '0;
            acc_q     <= '0;
            y_n_q     <= '0;
            y_valid_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                hist_q[i] <= '0;
                h_q[i]    <= '0;
            end
        end else begin
            case (state_q)
                StIdle: begin
                    // A write on the accepting edge is visible to this
                    // sample's MAC, which starts on the following edge.
                    if (coef_we) begin
                        h_q[coef_addr] <= coef_data;
                    end
                    if (x_valid) begin
                        hist_q[wr_ptr_q] <= x_n;
                        cur_ptr_q        <= wr_ptr_q;
                        wr_ptr_q         <= wr_ptr_q + 1'b1;
                        acc_q            <= '0;
                        k_q              <= '0;
                        state_q          <= StMac;
                    end
                end
                StMac: begin
                    if (k_q[AW]) begin
                        y_n_q     <= y_load;
                        y_valid_q <= 1'b1;
                        state_q   <= StHold;
                    end else begin
                        acc_q <= acc_q + prod_ext;
                        k_q   <= k_q + 1'b1;
                    end
                end
                StHold: begin
                    if (y_ready) begin
                        y_valid_q <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign x_ready = (state_q == StIdle);
    assign busy    = (state_q != StIdle);
    assign y_n     = y_n_q;
    assign y_valid = y_valid_q;

endmodule

// File: tb/tb_fir_tap_scheduler.sv
module tb_fir_tap_scheduler;

    localparam int N  = 32;
    localparam int AW = 5;
    localparam int LAT = N + 1;  // edges from accept edge to y_valid high

    logic               clk;
    logic               rst;
    logic signed [7:0]  x_n;
    logic               x_valid;
    logic               x_ready;
    logic signed [15:0] y_n;
    logic               y_valid;
    logic               y_ready;
    logic               coef_we;
    logic [AW-1:0]      coef_addr;
    logic signed [7:0]  coef_data;
    logic               busy;

    int vectors;
    int miscompares;

    fir_tap_scheduler #(
        .N  (N),
        .AW (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .x_n       (x_n),
        .x_valid   (x_valid),
        .x_ready   (x_ready),
        .y_n       (y_n),
        .y_valid   (y_valid),
        .y_ready   (y_ready),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // All tasks are entered and left 1 time unit after a rising edge.
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic write_coef(input int addr, input int data);
        coef_addr = AW'(addr);
        coef_data = 8'(data);
        coef_we   = 1'b1;
        @(posedge clk); #1;
        coef_we   = 1'b0;
    endtask

    task automatic accept(input int x);
        int n;
        n = 0;
        while (!x_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_ready", x_ready, 1);
        x_n     = 8'(x);
        x_valid = 1'b1;
        @(posedge clk); #1;
        x_valid = 1'b0;
    endtask

    // Waits for y_valid, returns y_n and edge count, then lets the handshake
    // complete (y_ready is high).
    task automatic get_y(output logic signed [15:0] y, output int lat);
        int n;
        n = 0;
        while (!y_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("y_valid_seen", y_valid, 1);
        y   = y_n;
        lat = n;
        @(posedge clk); #1;
    endtask

    logic signed [15:0] y;
    int lat;
    int n;

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst       = 1'b1;
        x_n       = '0;
        x_valid   = 1'b0;
        y_ready   = 1'b1;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset state
        chk("rst_x_ready", x_ready, 1);
        chk("rst_y_valid", y_valid, 0);
        chk("rst_y_n", y_n, 0);
        chk("rst_busy", busy, 0);

        // Impulse response: h[k]=k+1, x = 1 then 40 zeros
        for (int k = 0; k < N; k++) write_coef(k, k + 1);
        accept(1);
        chk("imp_busy_mac", busy, 1);
        chk("imp_x_ready_mac", x_ready, 0);
        get_y(y, lat);
        chk("imp_latency", lat, LAT);
        chk("imp_y0", y, 1);
        chk("imp_idle_x_ready", x_ready, 1);
        chk("imp_idle_busy", busy, 0);
        for (int i = 1; i <= 40; i++) begin
            accept(0);
            get_y(y, lat);
            chk($sformatf("imp_y%0d", i), y, (i < N) ? i + 1 : 0);
        end

        // Saturation and wrap: all h=127, 32 samples of 127
        do_reset();
        for (int k = 0; k < N; k++) write_coef(k, 127);
        for (int i = 0; i < N; i++) begin
            accept(127);
            get_y(y, lat);
            if (i == 0) chk("sat_y1", y, 16129);
            if (i == 1) chk("sat_y2", y, 32258);
`ifdef FIR_SAT_EN
            if (i == 2)     chk("sat_y3", y, 32767);
            if (i == N - 1) chk("sat_y32", y, 32767);
`else
            if (i == 2)     chk("sat_y3", y, -17149);
            if (i == N - 1) chk("sat_y32", y, -8160);
`endif
        end

        // Backpressure: h0=1, h1=2; x=3 held 10 cycles, x=100 offered meanwhile
        do_reset();
        write_coef(0, 1);
        write_coef(1, 2);
        y_ready = 1'b0;
        accept(3);
        n = 0;
        while (!y_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_y_valid_rise", y_valid, 1);
        chk("bp_y_n", y_n, 3);
        x_n     = 8'sd100;
        x_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk("bp_hold_y_valid", y_valid, 1);
            chk("bp_hold_y_n", y_n, 3);
            chk("bp_hold_x_ready", x_ready, 0);
        end
        x_valid = 1'b0;
        y_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_y_valid", y_valid, 0);
        chk("bp_release_x_ready", x_ready, 1);
        chk("bp_release_y_n", y_n, 3);
        accept(4);
        get_y(y, lat);
        chk("bp_next", y, 10);  // 1*4 + 2*3; the offered 100 was dropped

        // Coefficient write gating
        do_reset();
        write_coef(0, 1);
        write_coef(1, 1);
        accept(10);
        coef_addr = '0;
        coef_data = 8'sd5;
        coef_we   = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        coef_we = 1'b0;
        get_y(y, lat);
        chk("cw_ignored", y, 10);
        write_coef(0, 5);
        accept(10);
        get_y(y, lat);
        chk("cw_idle", y, 60);
        // Write and sample on the same edge: new h[0]=2 is used
        coef_addr = '0;
        coef_data = 8'sd2;
        coef_we   = 1'b1;
        x_n       = 8'sd1;
        x_valid   = 1'b1;
        @(posedge clk); #1;
        coef_we = 1'b0;
        x_valid = 1'b0;
        get_y(y, lat);
        chk("cw_same_edge", y, 12);

        // Reset mid-MAC
        do_reset();
        write_coef(0, 3);
        accept(7);
        get_y(y, lat);
        chk("rm_first", y, 21);
        accept(7);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rm_y_valid", y_valid, 0);
        chk("rm_x_ready", x_ready, 1);
        chk("rm_y_n", y_n, 0);
        chk("rm_busy", busy, 0);
        accept(1);
        get_y(y, lat);
        chk("rm_impulse", y, 0);

        // Pointer wrap: all h=1, 100 samples of 1
        do_reset();
        for (int k = 0; k < N; k++) write_coef(k, 1);
        for (int i = 0; i < 100; i++) begin
            accept(1);
            get_y(y, lat);
            chk($sformatf("wrap_y%0d", i), y, (i < N) ? i + 1 : N);
            chk("wrap_latency", lat, LAT);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
